peg_plotter: RTL and testbench

Downstream raster stage for the game control FSM. It takes one peg/feedback request (`draw`, anchor `x_in`/`y_in`, `color_in`) and rasterizes it as a SIZE×SIZE square, emitting one pixel per clock to the VGA adapter's `x`/`y`/`colour`/`plot` inputs. The control FSM holds `draw` high for a whole draw state, so the plotter triggers on the rising edge only and draws each square exactly once.

---
 rtl/peg_plotter.sv | 92 +++++++++
 tb/tb_peg_plotter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peg_plotter.sv
// peg_plotter: rasterizes one SIZE x SIZE square per rising edge of draw, one pixel per clock
// Ports:
//   clk, resetn              clock and asynchronous active-low reset
//   draw                     request level; only its rising edge starts a square
//   x_in, y_in, color_in     top-left corner and colour, latched at start
//   vga_x, vga_y, vga_colour current pixel for the VGA adapter
//   vga_plot                 write-enable for the current pixel
//   busy                     high from the first pixel through the done cycle
//   done                     one-cycle pulse after the last pixel
// Optional feature: define PEG_PLOTTER_ROUND_EN to suppress the four corner pixels.
module peg_plotter #(
    parameter int SIZE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       draw,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] color_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] L = 3'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

    state_t     state, state_n;
    logic       draw_q;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] col, cx, cy;
    logic       start, last_x, last;

    assign start  = draw & ~draw_q;
    assign last_x = cx == L;
    assign last   = last_x && cy == L;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? PLOT : IDLE;
            PLOT:    state_n = last ? DONE : PLOT;
            default: state_n = IDLE;
        endcase
    end

    // draw_q resets high so a draw already asserted at reset release is not an edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            draw_q <= 1'b1;
            x0     <= '0;
            y0     <= '0;
            col    <= '0;
            cx     <= '0;
            cy     <= '0;
        end else begin
            draw_q <= draw;
            if (state == IDLE && start) begin
                x0  <= x_in;
                y0  <= y_in;
                col <= color_in;
                cx  <= '0;
                cy  <= '0;
            end else if (state == PLOT) begin
                cx <= last_x ? 3'd0 : cx + 3'd1;
                cy <= last ? 3'd0 : last_x ? cy + 3'd1 : cy;
            end
        end
    end

    assign vga_x      = x0 + {5'd0, cx};
    assign vga_y      = y0 + {4'd0, cy};
    assign vga_colour = col;
    assign busy       = state != IDLE;
    assign done       = state == DONE;

`ifdef PEG_PLOTTER_ROUND_EN
    logic corner;
    assign corner   = (cx == 3'd0 || cx == L) && (cy == 3'd0 || cy == L);
    assign vga_plot = state == PLOT && !corner;
`else
    assign vga_plot = state == PLOT;
`endif
endmodule

// File: tb/tb_peg_plotter.sv
// tb_peg_plotter: directed self-checking bench for peg_plotter with SIZE=4
module tb_peg_plotter;
    logic       clk = 0;
    logic       resetn = 0;
    logic       draw = 0;
    logic [7:0] x_in = 0;
    logic [6:0] y_in = 0;
    logic [2:0] color_in = 0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    peg_plotter #(.SIZE(4)) dut (
        .clk(clk), .resetn(resetn), .draw(draw), .x_in(x_in), .y_in(y_in),
        .color_in(color_in), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // expected write-enable for pixel i of a 4x4 square
    function automatic logic exp_plot(input int i);
`ifdef PEG_PLOTTER_ROUND_EN
        return !((i % 4 == 0 || i % 4 == 3) && (i / 4 == 0 || i / 4 == 3));
`else
        return 1'b1;
`endif
    endfunction

    function automatic int exp_count();
`ifdef PEG_PLOTTER_ROUND_EN
        return 12;
`else
        return 16;
`endif
    endfunction

    task automatic test_reset();
        resetn = 0;
        draw = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d p=%b b=%b d=%b, want all 0",
                     vga_x, vga_y, vga_colour, vga_plot, busy, done);
        end
        resetn = 1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_square();
        int plots = 0, busy_cyc = 0;
        x_in = 38; y_in = 24; color_in = 3'b100; draw = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            plots += int'(vga_plot);
            busy_cyc += int'(busy);
            n_cmp++;
            if ({vga_x, vga_y, vga_colour, vga_plot, busy, done} !==
                {8'(38 + i % 4), 7'(24 + i / 4), 3'b100, exp_plot(i), 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL square_px%0d: got x=%0d y=%0d c=%0d p=%b b=%b d=%b, want x=%0d y=%0d c=4 p=%b b=1 d=0",
                         i, vga_x, vga_y, vga_colour, vga_plot, busy, done, 38 + i % 4, 24 + i / 4, exp_plot(i));
            end
        end
        @(negedge clk);
        busy_cyc += int'(busy);
        n_cmp++;
        if ({vga_plot, busy, done} !== 3'b011) begin
            n_bad++;
            $display("FAIL square_done: got p=%b b=%b d=%b, want p=0 b=1 d=1", vga_plot, busy, done);
        end
        n_cmp++;
        if (plots != exp_count()) begin
            n_bad++;
            $display("FAIL square_plots: got %0d want %0d", plots, exp_count());
        end
        @(negedge clk);
        busy_cyc += int'(busy);
        n_cmp++;
        if (busy_cyc != 17 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL square_busy: got busy cycles %0d done=%b, want 17 and 0", busy_cyc, done);
        end
    endtask

    task automatic test_hold();
        int busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            busy_cyc += int'(busy);
        end
        n_cmp++;
        if (busy_cyc != 0) begin
            n_bad++;
            $display("FAIL hold_no_retrigger: got %0d busy cycles want 0", busy_cyc);
        end
        draw = 0;
        @(negedge clk);
        x_in = 50; y_in = 60; color_in = 3'b011; draw = 1;
        @(negedge clk);
        n_cmp++;
        if ({vga_x, vga_y, vga_colour, busy} !== {8'd50, 7'd60, 3'b011, 1'b1}) begin
            n_bad++;
            $display("FAIL hold_retrigger: got x=%0d y=%0d c=%0d b=%b, want x=50 y=60 c=3 b=1",
                     vga_x, vga_y, vga_colour, busy);
        end
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        draw = 0;
        @(negedge clk);
    endtask

    task automatic test_ignore();
        int bad_x = 0, busy_cyc = 0;
        x_in = 38; y_in = 24; color_in = 3'b100; draw = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (vga_x !== 8'(38 + i % 4) || vga_colour !== 3'b100) bad_x++;
            if (i == 3) draw = 0;
            if (i == 4) begin
                draw = 1; x_in = 102; color_in = 3'b001;
            end
        end
        n_cmp++;
        if (bad_x != 0) begin
            n_bad++;
            $display("FAIL ignore_latched: %0d pixels off x 38..41 or colour 4, want 0", bad_x);
        end
        @(negedge clk);
        draw = 0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_done: done=%b want 1", done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_cyc += int'(busy);
        end
        n_cmp++;
        if (busy_cyc != 0) begin
            n_bad++;
            $display("FAIL ignore_not_queued: got %0d busy cycles want 0", busy_cyc);
        end
    endtask

    task automatic test_back_to_back();
        draw = 1; x_in = 1; y_in = 2; color_in = 3'b010;
        @(negedge clk);
        draw = 0;
        for (int i = 0; i < 30 && !done; i++) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done: done=%b want 1", done);
        end
        draw = 1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done_edge_ignored: busy=%b want 0", busy);
        end
        draw = 0;
        @(negedge clk);
        draw = 1; x_in = 7;
        @(negedge clk);
        n_cmp++;
        if ({busy, vga_plot, vga_x} !== {1'b1, exp_plot(0), 8'd7}) begin
            n_bad++;
            $display("FAIL b2b_idle_edge_accepted: got b=%b p=%b x=%0d, want b=1 p=%b x=7",
                     busy, vga_plot, vga_x, exp_plot(0));
        end
        draw = 0;
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        x_in = 254; y_in = 126; color_in = 3'b111; draw = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i % 5 == 0) begin
                n_cmp++;
                if ({vga_x, vga_y} !== {8'(254 + i % 4), 7'(126 + i / 4)}) begin
                    n_bad++;
                    $display("FAIL wrap_px%0d: got x=%0d y=%0d want x=%0d y=%0d",
                             i, vga_x, vga_y, 8'(254 + i % 4), 7'(126 + i / 4));
                end
            end
        end
        draw = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int busy_cyc = 0, done_cyc = 0;
        x_in = 10; y_in = 5; color_in = 3'b110; draw = 1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({vga_x, vga_y, vga_plot} !== {8'd13, 7'd6, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_px7: got x=%0d y=%0d p=%b want x=13 y=6 p=1", vga_x, vga_y, vga_plot);
        end
        resetn = 0;
        #1;
        n_cmp++;
        if ({vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 21'd0) begin
            n_bad++;
            $display("FAIL abort_immediate: got x=%0d y=%0d c=%0d p=%b b=%b d=%b, want all 0",
                     vga_x, vga_y, vga_colour, vga_plot, busy, done);
        end
        repeat (2) @(negedge clk);
        resetn = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_cyc += int'(busy);
            done_cyc += int'(done);
        end
        n_cmp++;
        if (busy_cyc != 0 || done_cyc != 0) begin
            n_bad++;
            $display("FAIL abort_no_restart: got busy %0d done %0d cycles, want 0 and 0", busy_cyc, done_cyc);
        end
        draw = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_square();
        test_hold();
        test_ignore();
        test_back_to_back();
        test_wrap();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
